module_tx_encoder: RTL
======================

# module_tx_encoder

Transmit-side Hamming(7,4) encoder for the link whose receive side computes the 3-bit syndrome. It accepts a 4-bit nibble through a valid/ready handshake and computes the 7-bit codeword in the bit layout the receiver checks. It can optionally flip one codeword bit for fault-injection demos. It presents the codeword in parallel and also shifts it out as a framed serial stream.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range ≥1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid_i  in  1  source has a nibble on data_i.
- in_ready_o  out  1  block can accept; high only in IDLE.
- data_i  in  4  nibble d[3:0].
- err_pos_i  in  3  injected error position. 0 = none; 1..7 flips codeword bit err_pos_i-1.
- code_o  out  7  registered codeword e[6:0], including any injected error.
- code_valid_o  out  1  one-cycle pulse when code_o updates.
- serial_o  out  1  serial line; idles high.
- busy_o  out  1  frame in progress.

## Operation
- Encoding and data mapping:
  - Data bits map to e2=d0, e4=d1, e5=d2, e6=d3.
  - Parity bits: e0=d0^d1^d3, e1=d0^d2^d3, e3=d1^d2^d3.
  - Fault injection: codeword ^= (err_pos_i≠0) ? 7'b1<<(err_pos_i-1) : 0.
  - Consequence at the receiver: the syndrome equals err_pos_i.
- Handshake:
  - Transfer occurs on the edge where in_valid_i && in_ready_o.
  - data_i and err_pos_i are sampled only at that edge; later changes have no effect.
  - in_valid_i while busy is ignored. There is no queue.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on transfer.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA stays for 7 bit periods, e0 first (LSB first), tracked by a 3-bit bit index.
  - DATA → STOP after e6.
  - STOP → IDLE after CLKS_PER_BIT cycles.
- serial_o by state: START drives 0, DATA drives the current bit, STOP and IDLE drive 1.
- Counters:
  - Cycle counter is $clog2(CLKS_PER_BIT+1) bits wide. It resets to 0 at each bit boundary.
  - Bit index wraps only by leaving DATA; it never wraps inside DATA.
- Reset values: state IDLE, in_ready_o=1, code_o=7'h00, code_valid_o=0, serial_o=1, busy_o=0, all counters 0.
- Reset mid-frame: on the next edge all outputs return to reset values and the partial frame is abandoned. code_o is cleared.

## Timing
- Transfer at edge k. On the cycle after edge k:
  - code_o holds the new codeword.
  - code_valid_o=1 for exactly that one cycle.
  - busy_o=1, in_ready_o=0.
  - serial_o=0 (start bit).
- Encode latency: 1 cycle from the transfer edge to code_o.
- Frame layout, C=CLKS_PER_BIT:
  - Start bit occupies cycles k+1 … k+C.
  - Bit e_i occupies cycles k+1+(i+1)C … k+(i+2)C.
  - Stop bit occupies cycles k+1+8C … k+9C.
- Frame end: in_ready_o=1 and busy_o=0 from cycle k+1+9C.
  - With in_valid_i held high, the earliest next transfer is the edge at the end of that cycle.
  - Consecutive transfers are therefore 9C+1 cycles apart.
- code_o holds its value until the next transfer or reset.
- in_ready_o and busy_o are decoded directly from registered state, with no combinational path from inputs.

## Structure
- Shared package hamming_pkg holds:
  - CODE_W=7 and DATA_W=4.
  - Function hamming74_encode(logic [3:0]) returning logic [6:0].
  - Function inject_error(code, pos).
  - The tx_state_t enum {IDLE, START, DATA, STOP}.
- The receive-side decoder's bench reuses hamming74_encode.
- One sub-module, module_tx_serializer, contains the FSM, the counters and serial_o. It takes a 7-bit word plus a load strobe and exposes ready/busy.
- The top level holds the handshake, the encode/inject logic and the code_o register.

## Test plan
- Reset, then data_i=4'b1011, err_pos_i=0, C=4:
  - code_o=7'h55 with a 1-cycle code_valid_o pulse.
  - serial_o sequence, 4 cycles each: 0,1,0,1,0,1,0,1,1. Total 36 cycles.
  - in_ready_o returns at cycle 37.
- Exhaustive nibbles 0..15 with err_pos_i=0:
  - Receiver syndrome is 0 for all.
  - 4'h0 gives 7'h00; 4'hF gives 7'h7F.
- Fault injection:
  - data 4'h0 with err_pos_i=3 gives code_o=7'h04 and receiver syndrome 3.
  - data 4'b1011 with err_pos_i=5 gives code_o=7'h45 and syndrome 5.
- in_valid_i held high with changing data_i during a frame:
  - Only one transfer per 9C+1 cycles.
  - Mid-frame data_i changes do not alter serial_o or code_o.
- rst asserted at cycle 10 of a frame:
  - Next cycle: serial_o=1, code_o=0, busy_o=0, in_ready_o=1.
  - A new transfer afterwards produces a complete, correct frame.
- CLKS_PER_BIT=1:
  - Frame lasts exactly 9 cycles.
  - Back-to-back transfers are 10 cycles apart with no glitch on serial_o.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the transmit encoder and the receive-side
// decoder: widths, the encoder, the fault-injection helper and the TX FSM states.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Codeword bit e[i] sits at Hamming position i+1, so data lands on positions
  // 3,5,6,7 and parity on 1,2,4; the receiver's syndrome is then the position
  // of a single flipped bit.
  function automatic logic [CODE_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] e;
    e[2] = d[0];
    e[4] = d[1];
    e[5] = d[2];
    e[6] = d[3];
    e[0] = d[0] ^ d[1] ^ d[3];
    e[1] = d[0] ^ d[2] ^ d[3];
    e[3] = d[1] ^ d[2] ^ d[3];
    return e;
  endfunction

  // pos = 0 leaves the codeword intact; pos = 1..7 flips bit pos-1.
  function automatic logic [CODE_W-1:0] inject_error(input logic [CODE_W-1:0] code,
                                                     input logic [2:0]        pos);
    logic [CODE_W-1:0] mask;
    mask = '0;
    if (pos != 3'd0) begin
      mask = CODE_W'(1) << (pos - 3'd1);
    end
    return code ^ mask;
  endfunction

endpackage : hamming_pkg

// File: rtl/module_tx_serializer.sv
// Frames a 7-bit codeword as start bit, e0..e6 (LSB first) and stop bit on a
// line that idles high. Each bit lasts CLKS_PER_BIT clock cycles.
module module_tx_serializer
  import hamming_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [CODE_W-1:0] i_word,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_serial
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(CODE_W - 1);

  tx_state_t         r_state;
  tx_state_t         w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_next;
  logic [CODE_W-1:0] r_word;
  logic              r_serial;
  logic              w_serial_next;
  logic              w_bit_end;

  assign w_bit_end = (r_cnt == LAST_CNT);

  // Next-state, cycle counter and bit index; the counter restarts at every bit boundary.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves
    // a value unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit_idx;
    unique case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        w_bit_next = '0;
        if (i_load) begin
          w_state_next = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_bit_next   = '0;
          w_state_next = DATA;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_bit_idx == LAST_BIT) begin
            w_bit_next   = '0;
            w_state_next = STOP;
          end else begin
            w_bit_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
        w_bit_next   = '0;
      end
    endcase
  end

  // Line level for the upcoming state, registered so serial_o is glitch-free.
  always_comb begin
    w_serial_next = 1'b1;
    unique case (w_state_next)
      START:   w_serial_next = 1'b0;
      DATA:    w_serial_next = r_word[w_bit_next];
      default: w_serial_next = 1'b1;
    endcase
  end

  // State, counters, line register and the captured word.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_word    <= '0;
      r_serial  <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_next;
      r_serial  <= w_serial_next;
      if (i_load && (r_state == IDLE)) begin
        r_word <= i_word;
      end
    end
  end

  assign o_ready  = (r_state == IDLE);
  assign o_busy   = (r_state != IDLE);
  assign o_serial = r_serial;

endmodule : module_tx_serializer

// File: rtl/module_tx_encoder.sv
// Hamming(7,4) transmit encoder: accepts a nibble on a valid/ready handshake,
// optionally flips one codeword bit, presents the codeword in parallel and
// hands it to the serializer for framed LSB-first transmission.
module module_tx_encoder
  import hamming_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        err_pos_i,
  output logic [CODE_W-1:0] code_o,
  output logic              code_valid_o,
  output logic              serial_o,
  output logic              busy_o
);

  logic              w_ready;
  logic              w_busy;
  logic              w_serial;
  logic              w_transfer;
  logic [CODE_W-1:0] w_code;
  logic [CODE_W-1:0] r_code;
  logic              r_code_valid;

  assign w_transfer = in_valid_i && w_ready;
  assign w_code     = inject_error(hamming74_encode(data_i), err_pos_i);

  // Capture the codeword on a transfer and pulse code_valid for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code       <= '0;
      r_code_valid <= 1'b0;
    end else begin
      r_code_valid <= w_transfer;
      if (w_transfer) begin
        r_code <= w_code;
      end
    end
  end

  module_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_transfer),
    .i_word  (w_code),
    .o_ready (w_ready),
    .o_busy  (w_busy),
    .o_serial(w_serial)
  );

  assign in_ready_o   = w_ready;
  assign busy_o       = w_busy;
  assign serial_o     = w_serial;
  assign code_o       = r_code;
  assign code_valid_o = r_code_valid;

endmodule : module_tx_encoder
